// File: rtl/alu_ctrl_stage.sv
// Registered ALU sub-control decode stage between ID and EX, with a valid/ready handshake.
// Define RV_MULDIV_EN to decode M-extension ops and hold them MD_LATENCY cycles.
module alu_ctrl_stage #(
  parameter int XLEN       = 32,
  parameter int MD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  aluop,
  input  logic [31:0] in1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  outsel,
  output logic [2:0]  br_cond,
  output logic        illegal,
  output logic [2:0]  md_op,
  output logic        md_sel
);

  localparam logic [3:0] SEL_AND   = 4'b0000;
  localparam logic [3:0] SEL_OR    = 4'b0001;
  localparam logic [3:0] SEL_ADD   = 4'b0010;
  localparam logic [3:0] SEL_PASSB = 4'b0011;
  localparam logic [3:0] SEL_SUB   = 4'b0110;
  localparam logic [3:0] SEL_SLT   = 4'b0111;
  localparam logic [3:0] SEL_SLTU  = 4'b1000;
  localparam logic [3:0] SEL_SLL   = 4'b1001;
  localparam logic [3:0] SEL_SRL   = 4'b1010;
  localparam logic [3:0] SEL_SRA   = 4'b1011;
  localparam logic [3:0] SEL_XOR   = 4'b1100;
  localparam logic [3:0] SEL_NONE  = 4'b1111;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic       WIDE_SHAMT = (XLEN == 64);

  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       shamt_hi_bad;
  logic       unused_in1;

  assign funct3       = in1[14:12];
  assign funct7       = in1[31:25];
  // Bit 25 is the top shamt bit only on RV64; on RV32 it marks a malformed shift.
  assign shamt_hi_bad = in1[25] && !WIDE_SHAMT;
  assign unused_in1   = ^{in1[24:15], in1[11:7]};

  logic [3:0] dec_outsel;
  logic [2:0] dec_br;
  logic       dec_illegal;
  logic       dec_md;

`ifdef RV_MULDIV_EN
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [3:0] MD_LOAD   = 4'(MD_LATENCY - 1);
  assign dec_md = (aluop == 2'b01) && (funct7 == F7_MULDIV);
`else
  logic [3:0] unused_md_latency;
  assign unused_md_latency = 4'(MD_LATENCY);
  assign dec_md = 1'b0;
`endif

  always_comb begin
    dec_outsel  = SEL_NONE;
    dec_br      = 3'b000;
    dec_illegal = 1'b0;
    case (aluop)
      2'b00: dec_outsel = (in1[6:0] == OPC_LUI) ? SEL_PASSB : SEL_ADD;
      2'b01: begin
        if (dec_md) begin
          dec_outsel = SEL_NONE;
        end else if (funct7 != F7_BASE && funct7 != F7_ALT) begin
          dec_illegal = 1'b1;
        end else begin
          case ({in1[30], funct3})
            4'b0000: dec_outsel = SEL_ADD;
            4'b1000: dec_outsel = SEL_SUB;
            4'b0001: dec_outsel = SEL_SLL;
            4'b0010: dec_outsel = SEL_SLT;
            4'b0011: dec_outsel = SEL_SLTU;
            4'b0100: dec_outsel = SEL_XOR;
            4'b0101: dec_outsel = SEL_SRL;
            4'b1101: dec_outsel = SEL_SRA;
            4'b0110: dec_outsel = SEL_OR;
            4'b0111: dec_outsel = SEL_AND;
            default: dec_illegal = 1'b1;
          endcase
        end
      end
      2'b10: begin
        dec_br = funct3;
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          dec_illegal = 1'b1;
        end else begin
          dec_outsel = in1[13] ? SEL_SLTU : SEL_SLT;
        end
      end
      2'b11: begin
        case (funct3)
          3'b000: dec_outsel = SEL_ADD;
          3'b010: dec_outsel = SEL_SLT;
          3'b011: dec_outsel = SEL_SLTU;
          3'b100: dec_outsel = SEL_XOR;
          3'b110: dec_outsel = SEL_OR;
          3'b111: dec_outsel = SEL_AND;
          3'b001: begin
            if (in1[31:26] != 6'b000000 || shamt_hi_bad) dec_illegal = 1'b1;
            else dec_outsel = SEL_SLL;
          end
          default: begin
            if (shamt_hi_bad) dec_illegal = 1'b1;
            else dec_outsel = in1[30] ? SEL_SRA : SEL_SRL;
          end
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) dec_outsel = SEL_NONE;
  end

  logic       out_valid_q, out_valid_d;
  logic [3:0] outsel_q, outsel_d;
  logic [2:0] br_cond_q, br_cond_d;
  logic       illegal_q, illegal_d;
  logic       accept;

`ifdef RV_MULDIV_EN
  logic       md_sel_q, md_sel_d;
  logic [2:0] md_op_q, md_op_d;
  logic [3:0] busy_q, busy_d;

  assign in_ready = (busy_q == 4'd0) && (!out_valid_q || out_ready);
  assign md_sel   = md_sel_q;
  assign md_op    = md_op_q;
`else
  assign in_ready = !out_valid_q || out_ready;
  assign md_sel   = 1'b0;
  assign md_op    = 3'b000;
`endif

  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign outsel    = outsel_q;
  assign br_cond   = br_cond_q;
  assign illegal   = illegal_q;

  // A held M-op keeps its fields in the output register with out_valid low until the count expires.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    outsel_d    = outsel_q;
    br_cond_d   = br_cond_q;
    illegal_d   = illegal_q;
`ifdef RV_MULDIV_EN
    md_sel_d = md_sel_q;
    md_op_d  = md_op_q;
    busy_d   = busy_q;
    if (busy_q != 4'd0) begin
      busy_d = busy_q - 4'd1;
      if (busy_q == 4'd1) out_valid_d = 1'b1;
    end
`endif
    if (accept) begin
      out_valid_d = 1'b1;
      outsel_d    = dec_outsel;
      br_cond_d   = dec_br;
      illegal_d   = dec_illegal;
`ifdef RV_MULDIV_EN
      md_sel_d = dec_md;
      md_op_d  = dec_md ? funct3 : 3'b000;
      if (dec_md && MD_LOAD != 4'd0) begin
        busy_d      = MD_LOAD;
        out_valid_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      outsel_q    <= SEL_NONE;
      br_cond_q   <= 3'b000;
      illegal_q   <= 1'b0;
`ifdef RV_MULDIV_EN
      md_sel_q <= 1'b0;
      md_op_q  <= 3'b000;
      busy_q   <= 4'd0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      outsel_q    <= outsel_d;
      br_cond_q   <= br_cond_d;
      illegal_q   <= illegal_d;
`ifdef RV_MULDIV_EN
      md_sel_q <= md_sel_d;
      md_op_q  <= md_op_d;
      busy_q   <= busy_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage: directed vector table, handshake corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_alu_ctrl_stage;

  localparam int XLEN_P   = 32;
  localparam int MD_LAT_P = 4;

  // funct3-indexed selects shared by R-type (funct7=0) and I-type ALU ops
  localparam logic [3:0] PLAIN_SEL [8] = '{4'h2, 4'h9, 4'h7, 4'h8, 4'hC, 4'hA, 4'h1, 4'h0};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  aluop;
  logic [31:0] in1;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  outsel;
  logic [2:0]  br_cond;
  logic        illegal;
  logic [2:0]  md_op;
  logic        md_sel;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_ctrl_stage #(.XLEN(XLEN_P), .MD_LATENCY(MD_LAT_P)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .in1(in1), .out_valid(out_valid), .out_ready(out_ready),
    .outsel(outsel), .br_cond(br_cond), .illegal(illegal),
    .md_op(md_op), .md_sel(md_sel)
  );

  typedef struct packed {
    logic [1:0]  aluop;
    logic [31:0] in1;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [18];

  // Result bundle layout: {outsel, br_cond, illegal, md_sel, md_op}
  function automatic logic [11:0] exp_of(input logic [3:0] sel, input logic [2:0] br, input logic ill);
    return {sel, br, ill, 1'b0, 3'b000};
  endfunction

  function automatic logic [11:0] out_bundle();
    return {outsel, br_cond, illegal, md_sel, md_op};
  endfunction

  // Reference decode from the instruction-set rules, one mnemonic group at a time
  function automatic logic [11:0] ref_decode(input logic [1:0] op, input logic [31:0] ins);
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] sel;
    logic [2:0] br;
    logic       bad;
    logic       mds;
    logic [2:0] mdo;
    logic       shift_ok;
    f3 = ins[14:12];
    f7 = ins[31:25];
    sel = 4'hF;
    br = 3'b000;
    bad = 1'b0;
    mds = 1'b0;
    mdo = 3'b000;
    shift_ok = (XLEN_P == 64) || !ins[25];
    if (op == 2'b00) begin
      sel = (ins[6:0] == 7'h37) ? 4'h3 : 4'h2;
    end else if (op == 2'b01) begin
`ifdef RV_MULDIV_EN
      if (f7 == 7'h01) begin
        mds = 1'b1;
        mdo = f3;
      end else
`endif
      if (f7 == 7'h00) sel = PLAIN_SEL[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) sel = 4'h6;
      else if (f7 == 7'h20 && f3 == 3'd5) sel = 4'hB;
      else bad = 1'b1;
    end else if (op == 2'b10) begin
      br = f3;
      if (f3 == 3'd2 || f3 == 3'd3) bad = 1'b1;
      else sel = ins[13] ? 4'h8 : 4'h7;
    end else begin
      if (f3 == 3'd1) begin
        bad = !(ins[31:26] == 6'd0 && shift_ok);
        sel = 4'h9;
      end else if (f3 == 3'd5) begin
        bad = !shift_ok;
        sel = ins[30] ? 4'hB : 4'hA;
      end else begin
        sel = PLAIN_SEL[f3];
      end
    end
    if (bad) sel = 4'hF;
    return {sel, br, bad, mds, mdo};
  endfunction

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] ins,
                               input logic ordy);
    in_valid  = v;
    aluop     = op;
    in1       = ins;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins;
    ins = $urandom;
    case ($urandom_range(0, 3))
      0: ins[31:25] = 7'h00;
      1: ins[31:25] = 7'h20;
      2: ins[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 3) == 0) ins[6:0] = 7'h37;
    if ($urandom_range(0, 1) == 0) ins[25] = 1'b0;
    return ins;
  endfunction

  // Random-phase model state: one outstanding result and the cycle it becomes visible
  int          cyc;
  int          due;
  logic        have_item;
  logic [11:0] item;

  initial begin
    vecs[0]  = '{2'b01, 32'h003100B3, exp_of(4'h2, 3'd0, 1'b0)};
    vecs[1]  = '{2'b01, 32'h403100B3, exp_of(4'h6, 3'd0, 1'b0)};
    vecs[2]  = '{2'b11, 32'h40315093, exp_of(4'hB, 3'd0, 1'b0)};
    vecs[3]  = '{2'b11, 32'h02315093, (XLEN_P == 64) ? exp_of(4'hA, 3'd0, 1'b0)
                                                      : exp_of(4'hF, 3'd0, 1'b1)};
    vecs[4]  = '{2'b10, 32'h00006063, exp_of(4'h8, 3'd6, 1'b0)};
    vecs[5]  = '{2'b10, 32'h00002063, exp_of(4'hF, 3'd2, 1'b1)};
    vecs[6]  = '{2'b10, 32'h00000063, exp_of(4'h7, 3'd0, 1'b0)};
    vecs[7]  = '{2'b00, 32'h123452B7, exp_of(4'h3, 3'd0, 1'b0)};
    vecs[8]  = '{2'b00, 32'h00012083, exp_of(4'h2, 3'd0, 1'b0)};
    vecs[9]  = '{2'b01, 32'h403110B3, exp_of(4'hF, 3'd0, 1'b1)};
    vecs[10] = '{2'b01, 32'h003150B3, exp_of(4'hA, 3'd0, 1'b0)};
    vecs[11] = '{2'b01, 32'h003170B3, exp_of(4'h0, 3'd0, 1'b0)};
    vecs[12] = '{2'b11, 32'h40311093, exp_of(4'hF, 3'd0, 1'b1)};
    vecs[13] = '{2'b11, 32'h00311093, exp_of(4'h9, 3'd0, 1'b0)};
    vecs[14] = '{2'b11, 32'h40314093, exp_of(4'hC, 3'd0, 1'b0)};
    vecs[15] = '{2'b01, 32'h203100B3, exp_of(4'hF, 3'd0, 1'b1)};
    vecs[16] = '{2'b01, 32'h403150B3, exp_of(4'hB, 3'd0, 1'b0)};
    vecs[17] = '{2'b10, 32'h00005063, exp_of(4'h7, 3'd5, 1'b0)};

    // Reset held two cycles, then released idle
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset out_valid", out_valid, 1'b0);
    checkOutput("reset in_ready", in_ready, 1'b1);
    checkOutput("reset fields", out_bundle(), exp_of(4'hF, 3'd0, 1'b0));
    @(negedge clk);
    checkOutput("idle out_valid", out_valid, 1'b0);

    // Back-to-back stream of table vectors with the sink always ready
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b1, vecs[i].aluop, vecs[i].in1, 1'b1);
      #1;
      checkOutput($sformatf("vec%0d in_ready", i), in_ready, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("vec%0d out_valid", i), out_valid, 1'b1);
      checkOutput($sformatf("vec%0d fields", i), out_bundle(), vecs[i].exp);
    end
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("drain out_valid", out_valid, 1'b0);

    // Backpressure: branch result held for three cycles while a new request waits
    applyStimulus(1'b1, 2'b10, 32'h00006063, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 32'h003100B3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("stall%0d in_ready", k), in_ready, 1'b0);
      checkOutput($sformatf("stall%0d out_valid", k), out_valid, 1'b1);
      checkOutput($sformatf("stall%0d fields", k), out_bundle(), exp_of(4'h8, 3'd6, 1'b0));
      @(negedge clk);
    end
    applyStimulus(1'b1, 2'b01, 32'h003100B3, 1'b1);
    #1;
    checkOutput("release in_ready", in_ready, 1'b1);
    @(negedge clk);
    checkOutput("release fields", out_bundle(), exp_of(4'h2, 3'd0, 1'b0));
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b1);
    @(negedge clk);

    // Divide request: multi-cycle with the M extension, otherwise an illegal encoding
    applyStimulus(1'b1, 2'b01, 32'h023140B3, 1'b1);
    #1;
    checkOutput("div in_ready", in_ready, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b1);
`ifdef RV_MULDIV_EN
    for (int k = 0; k < MD_LAT_P - 1; k++) begin
      #1;
      checkOutput($sformatf("div busy%0d in_ready", k), in_ready, 1'b0);
      checkOutput($sformatf("div busy%0d out_valid", k), out_valid, 1'b0);
      @(negedge clk);
    end
    checkOutput("div out_valid", out_valid, 1'b1);
    checkOutput("div fields", out_bundle(), {4'hF, 3'd0, 1'b0, 1'b1, 3'b100});
`else
    checkOutput("div out_valid", out_valid, 1'b1);
    checkOutput("div fields", out_bundle(), exp_of(4'hF, 3'd0, 1'b1));
`endif
    @(negedge clk);

    // Reset arriving while a divide is still in flight
    applyStimulus(1'b1, 2'b01, 32'h023140B3, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b1);
    #1;
    checkOutput("midreset out_valid", out_valid, 1'b0);
    checkOutput("midreset in_ready", in_ready, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("midreset no stale result", out_valid, 1'b0);

    // Randomized traffic against the transaction model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    due = 0;
    have_item = 1'b0;
    item = '0;
    for (int c = 0; c < 800; c++) begin
      logic        v;
      logic        ordy;
      logic [1:0]  op;
      logic [31:0] ins;
      logic        exp_ov;
      logic        exp_ir;
      logic        fire;
      logic        acc;
      v    = ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < 65);
      op   = 2'($urandom_range(0, 3));
      ins  = gen_instr();
      applyStimulus(v, op, ins, ordy);
      #1;
      exp_ov = have_item && (cyc >= due);
      exp_ir = !have_item || (exp_ov && ordy);
      checkOutput("rnd out_valid", out_valid, exp_ov);
      checkOutput("rnd in_ready", in_ready, exp_ir);
      if (exp_ov) checkOutput("rnd fields", out_bundle(), item);
      fire = exp_ov && ordy;
      acc  = v && exp_ir;
      @(negedge clk);
      cyc++;
      if (fire) have_item = 1'b0;
      if (acc) begin
        have_item = 1'b1;
        item = ref_decode(op, ins);
        due = cyc + (item[3] ? MD_LAT_P - 1 : 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
